ddr_line_fetch: RTL
===================

// Module: ddr_line_fetch
// PURPOSE
//  Per-line read scheduler between the display line buffers and the DDR2 manager read port.
//  After buffer preload completes, it prefetches line 0 into line-buffer bank 0.
//  Each later line_req fetches the next line into the other bank of a ping-pong pair.
//  It drives rd_xfr_en/rd_mem_addr and counts completed frames (screen_cnt).
// PARAMETERS
//  DATA_W          32   user read data width (one word = two 16-bit pixels)
//  ROW_W           13   DDR2 row address width; one display line = one row
//  WORDS_PER_LINE  320  read words per line (640 px x 16 bit / 32)
//  LINES_PER_FRAME 480  active lines per frame
//  FRAME_CNT_W     16   screen_cnt width
// PORTS
//  clk            in   1                 system clock
//  rst            in   1                 synchronous reset, active-high
//  init_done      in   1                 DDR2 preload done (level)
//  line_req       in   1                 1-cycle pulse: display consumed a bank, fetch next line
//  rd_xfr_en      out  1                 read request to DDR manager
//  rd_mem_addr    out  ROW_W             row address of requested line
//  rd_xfr_ack     in   1                 manager accepted request (same-cycle with rd_xfr_en)
//  rd_data_vld    in   1                 read word valid
//  rd_data        in   DATA_W            read word
//  lb_wr_en       out  1                 line-buffer write strobe
//  lb_wr_addr     out  1+clog2(WPL)      {bank, word index}
//  lb_wr_data     out  DATA_W            registered rd_data
//  line_ready     out  1                 1-cycle pulse: bank lb_wr_addr[MSB] of last write full
//  screen_cnt     out  FRAME_CNT_W       completed frames, wraps
//  overrun        out  1                 sticky: line_req while fetch not idle
//  diag_err       out  1                 sticky data-pattern error (LINE_DIAG_EN only)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, line_idx 0, bank 0, word_cnt 0.
//  FSM IDLE -> REQ when init_done=1 (prefetch line 0, bank 0).
//   REQ: rd_xfr_en=1, rd_mem_addr=line_idx; both held stable until rd_xfr_ack; -> XFER next cycle.
//   XFER: each rd_data_vld -> lb_wr_en=1 one cycle later, addr={bank,word_cnt}, word_cnt++.
//     The write for word WORDS_PER_LINE-1 is registered -> DONE.
//   DONE (1 cycle): line_ready=1; bank toggles; word_cnt=0.
//     line_idx++; at LINES_PER_FRAME-1, line_idx wraps to 0 and screen_cnt++ (mod 2^FRAME_CNT_W).
//     -> WAIT.
//   WAIT: line_req -> REQ.
//  Latency: rd_data_vld -> lb_wr_en: 1 cycle. Last write -> line_ready: next cycle.
//  line_req in IDLE/REQ/XFER/DONE: overrun<=1, request dropped; no queueing.
//  rd_data_vld outside XFER: ignored, no write.
//  init_done deasserts: no effect once past IDLE.
//  rst mid-transfer: immediate return to IDLE; words still in flight from the manager are ignored.
//  rd_mem_addr = line_idx zero-extended/truncated to ROW_W.
// CONFIGURATION
//  LINE_DIAG_EN defined: each accepted word is checked against the preload pattern.
//    Both 16-bit halves must equal {5'b0, line_idx[10:0]}; a mismatch sets diag_err (sticky until rst).
//    Compare occurs in the lb_wr_en cycle.
//  LINE_DIAG_EN undefined: checker not built, diag_err tied 0.
// STRUCTURE
//  ddr_line_fetch_pkg: fetch_state_e {IDLE,REQ,XFER,DONE,WAIT};
//    DIAG_PAD_W=5, PIX_W=16 constants.
//  Sub-module ddr_line_diag (pattern checker): instantiated only under LINE_DIAG_EN.
//  FSM, counters and bank bit stay in ddr_line_fetch.
// TESTING
//  1 rst=1 5 cycles, init_done=0: all outputs 0, no rd_xfr_en.
//  2 init_done=1, ack 5 cycles later: rd_xfr_en=1, rd_mem_addr=0 held 6 cycles;
//    drops the cycle after ack.
//  3 Line transfer: 320 vld words, with gaps -> 320 lb_wr_en to addrs 0..319 bank 0;
//    then line_ready; next fetch writes bank 1.
//  4 Frame wrap: complete 480 lines -> 481st request has rd_mem_addr=0; screen_cnt=1.
//  5 line_req during XFER -> overrun=1; no extra request; fetch completes normally.
//  6 LINE_DIAG_EN: corrupt word 17 of line 3 to 0x0000_0004 -> diag_err=1.
//    Clean run keeps diag_err=0.

Source files
------------

// File: rtl/ddr_line_fetch_pkg.sv
`default_nettype none
// =============================================================================
// ddr_line_fetch_pkg : fetch FSM states, diag pattern constants and helper
// Rev 1.0
// =============================================================================
package ddr_line_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    XFER = 3'd2,
    DONE = 3'd3,
    WAIT = 3'd4
  } fetch_state_e;

  localparam int DIAG_PAD_W  = 5;
  localparam int PIX_W       = 16;
  localparam int DIAG_LINE_W = PIX_W - DIAG_PAD_W;

  // Preload writes every pixel of a line with the zero-padded line number.
  function automatic logic [PIX_W-1:0] diag_pattern(input logic [DIAG_LINE_W-1:0] line);
    return {{DIAG_PAD_W{1'b0}}, line};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_line_fetch_if.sv
`default_nettype none
// =============================================================================
// ddr_line_fetch_if : DDR2 manager read port (request + returned data)
// Rev 1.0
// =============================================================================
interface ddr_line_fetch_if #(
  parameter int ROW_W  = 13,
  parameter int DATA_W = 32
);
  logic              rd_xfr_en;
  logic [ROW_W-1:0]  rd_mem_addr;
  logic              rd_xfr_ack;
  logic              rd_data_vld;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output rd_xfr_en, rd_mem_addr,
    input  rd_xfr_ack, rd_data_vld, rd_data
  );

  modport slave (
    input  rd_xfr_en, rd_mem_addr,
    output rd_xfr_ack, rd_data_vld, rd_data
  );
endinterface
`default_nettype wire

// File: rtl/ddr_line_diag.sv
`default_nettype none
// =============================================================================
// ddr_line_diag : sticky checker of line-buffer writes against preload pattern
// Rev 1.0
// =============================================================================
module ddr_line_diag
  import ddr_line_fetch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic [DATA_W-1:0]      wr_data_i,
  input  logic [DIAG_LINE_W-1:0] line_i,
  output logic                   diag_err_o
);

  localparam int N_PIX = DATA_W / PIX_W;

  logic [PIX_W-1:0] w_expect;
  logic             w_mismatch;
  logic             diag_err_q;

  assign w_expect = diag_pattern(line_i);

  always_comb begin
    w_mismatch = 1'b0;
    for (int i = 0; i < N_PIX; i++) begin
      if (wr_data_i[i*PIX_W +: PIX_W] != w_expect) w_mismatch = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      diag_err_q <= 1'b0;
    end else if (wr_en_i && w_mismatch) begin
      diag_err_q <= 1'b1;
    end
  end

  assign diag_err_o = diag_err_q;

endmodule
`default_nettype wire

// File: rtl/ddr_line_fetch.sv
`default_nettype none
// =============================================================================
// ddr_line_fetch : per-line DDR2 read scheduler into ping-pong line buffers.
// Optional LINE_DIAG_EN builds the preload pattern checker.   Rev 1.0
// =============================================================================
module ddr_line_fetch
  import ddr_line_fetch_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int ROW_W           = 13,
  parameter int WORDS_PER_LINE  = 320,
  parameter int LINES_PER_FRAME = 480,
  parameter int FRAME_CNT_W     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              init_done_i,
  input  logic                              line_req_i,
  ddr_line_fetch_if.master                  rd_if,
  output logic                              lb_wr_en_o,
  output logic [$clog2(WORDS_PER_LINE):0]   lb_wr_addr_o,
  output logic [DATA_W-1:0]                 lb_wr_data_o,
  output logic                              line_ready_o,
  output logic [FRAME_CNT_W-1:0]            screen_cnt_o,
  output logic                              overrun_o,
  output logic                              diag_err_o
);

  localparam int WPL_W  = $clog2(WORDS_PER_LINE);
  localparam int LINE_W = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;

  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_REQ  = REQ;
  localparam logic [2:0] ST_XFER = XFER;
  localparam logic [2:0] ST_DONE = DONE;
  localparam logic [2:0] ST_WAIT = WAIT;

  localparam logic [WPL_W-1:0]  LAST_WORD = WPL_W'(WORDS_PER_LINE - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES_PER_FRAME - 1);

  logic [2:0]             state_q, state_d;
  logic [LINE_W-1:0]      line_idx_q;
  logic                   bank_q;
  logic [WPL_W-1:0]       word_cnt_q;
  logic                   wr_en_q;
  logic [WPL_W:0]         wr_addr_q;
  logic [DATA_W-1:0]      wr_data_q;
  logic                   line_ready_q;
  logic [FRAME_CNT_W-1:0] screen_cnt_q;
  logic                   overrun_q;
  logic                   w_word_acc;
  logic                   w_last_word;

  assign w_word_acc  = (state_q == ST_XFER) && rd_if.rd_data_vld;
  assign w_last_word = w_word_acc && (word_cnt_q == LAST_WORD);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (init_done_i)      state_d = ST_REQ;
      ST_REQ:  if (rd_if.rd_xfr_ack) state_d = ST_XFER;
      ST_XFER: if (w_last_word)      state_d = ST_DONE;
      ST_DONE:                       state_d = ST_WAIT;
      ST_WAIT: if (line_req_i)       state_d = ST_REQ;
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      line_idx_q   <= '0;
      bank_q       <= 1'b0;
      word_cnt_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      line_ready_q <= 1'b0;
      screen_cnt_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= w_word_acc;
      // DONE is the cycle the last word sits on the write port, so ready follows it.
      line_ready_q <= (state_q == ST_DONE);
      if (w_word_acc) begin
        wr_addr_q  <= {bank_q, word_cnt_q};
        wr_data_q  <= rd_if.rd_data;
        word_cnt_q <= word_cnt_q + WPL_W'(1);
      end
      if (state_q == ST_DONE) begin
        bank_q     <= ~bank_q;
        word_cnt_q <= '0;
        if (line_idx_q == LAST_LINE) begin
          line_idx_q   <= '0;
          screen_cnt_q <= screen_cnt_q + FRAME_CNT_W'(1);
        end else begin
          line_idx_q   <= line_idx_q + LINE_W'(1);
        end
      end
      if (line_req_i && (state_q != ST_WAIT)) overrun_q <= 1'b1;
    end
  end

  assign rd_if.rd_xfr_en   = (state_q == ST_REQ);
  assign rd_if.rd_mem_addr = ROW_W'(line_idx_q);

  assign lb_wr_en_o   = wr_en_q;
  assign lb_wr_addr_o = wr_addr_q;
  assign lb_wr_data_o = wr_data_q;
  assign line_ready_o = line_ready_q;
  assign screen_cnt_o = screen_cnt_q;
  assign overrun_o    = overrun_q;

`ifdef LINE_DIAG_EN
  ddr_line_diag #(
    .DATA_W (DATA_W)
  ) u_diag (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en_q),
    .wr_data_i  (wr_data_q),
    .line_i     (DIAG_LINE_W'(line_idx_q)),
    .diag_err_o (diag_err_o)
  );
`else
  assign diag_err_o = 1'b0;
`endif

endmodule
`default_nettype wire
